alu_gen: RTL and testbench

Parametrised successor to the TD4 add-only ALU. Widens the datapath to WIDTH bits and adds an opcode-selected operation set with registered result and flags (C, Z). Adds an optional iterative shift-add multiplier behind a start/busy/done handshake. Sits between the register file and the accumulator/flag logic of the CPU core; the sequencer waits for done before writeback.

---
 rtl/alu_gen_pkg.sv | 18 +
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_gen.sv | 146 ++++++++++++++
 tb/tb_alu_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_gen_pkg.sv
// Shared opcode and state definitions for the parametrised ALU.
package alu_gen_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier; the first step happens on the
// load edge so the full product is ready WIDTH-1 edges later (last=1).
module alu_mul_iter
    import alu_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt_d    = CW'(1);
        end else if (cnt_q == CW'(WIDTH)) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = acc_q;
    assign last    = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/alu_gen.sv
// WIDTH-bit ALU with registered result/C/Z flags and an optional
// multi-cycle multiplier behind a start/busy/done handshake.
module alu_gen
    import alu_gen_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flagC,
    output logic             flagZ
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               done_q, done_d;
    logic               mul_load;
    logic [2*WIDTH-1:0] product;
    logic               mul_last;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum;

    generate
        if (ENABLE_MUL) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clock   (clock),
                .reset   (reset),
                .load    (mul_load),
                .a       (a),
                .b       (b),
                .product (product),
                .last    (mul_last)
            );
        end else begin : g_nomul
            assign product  = '0;
            assign mul_last = 1'b0;
        end
    endgenerate

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): sum = {1'b0, a} + {1'b0, b};
            (op == OP_ADC): sum = {1'b0, a} + {1'b0, b}
                                + {{WIDTH{1'b0}}, c_q};
            (op == OP_SUB): sum = {1'b0, a} + {1'b0, ~b}
                                + {{WIDTH{1'b0}}, 1'b1};
            default: sum = '0;
        endcase
        unique case (1'b1)
            (op == OP_ADD),
            (op == OP_ADC): begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            // no carry-out of a + ~b + 1 means a borrow occurred
            (op == OP_SUB): begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = ~sum[WIDTH];
            end
            (op == OP_AND): alu_res = a & b;
            (op == OP_OR):  alu_res = a | b;
            (op == OP_XOR): alu_res = a ^ b;
            (op == OP_SHL): begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL && ENABLE_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        done_d = 1'b1;
                        if (op != OP_MUL) begin
                            result_d = alu_res;
                            c_d      = alu_c;
                            z_d      = (alu_res == '0);
                        end
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    result_d = product[WIDTH-1:0];
                    c_d      = |product[2*WIDTH-1:WIDTH];
                    z_d      = (product[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ST_MUL);
    assign done   = done_q;
    assign result = result_q;
    assign flagC  = c_q;
    assign flagZ  = z_q;

endmodule

// File: tb/tb_alu_gen.sv
// Scoreboard bench for alu_gen: one MUL-enabled and one MUL-disabled build.
module tb_alu_gen;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [2:0] op = '0, op2 = '0;
    logic [3:0] a = '0, b = '0, a2 = '0, b2 = '0;
    logic       busy, done, fc, fz;
    logic       busy2, done2, fc2, fz2;
    logic [3:0] res, res2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_gen #(.WIDTH(4), .ENABLE_MUL(1'b1)) dut (
        .clock(clk), .reset(rst_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(res), .flagC(fc), .flagZ(fz)
    );

    alu_gen #(.WIDTH(4), .ENABLE_MUL(1'b0)) dut2 (
        .clock(clk), .reset(rst_n), .start(start2), .op(op2),
        .a(a2), .b(b2), .busy(busy2), .done(done2),
        .result(res2), .flagC(fc2), .flagZ(fz2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1 result", int'(res), int'(e.res));
                chk("dut1 flagC", int'(fc), int'(e.c));
                chk("dut1 flagZ", int'(fz), int'(e.z));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected done", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("dut2 result", int'(res2), int'(e.res));
                chk("dut2 flagC", int'(fc2), int'(e.c));
                chk("dut2 flagZ", int'(fz2), int'(e.z));
            end
        end
    end

    // Called #1 after a rising edge; holds start for exactly one edge.
    task automatic issue(input logic [2:0] o, input logic [3:0] x,
                         input logic [3:0] y, input exp_t e,
                         input bit push);
        start = 1'b1; op = o; a = x; b = y;
        if (push) q1.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue2(input logic [2:0] o, input logic [3:0] x,
                          input logic [3:0] y, input exp_t e);
        start2 = 1'b1; op2 = o; a2 = x; b2 = y;
        q2.push_back(e);
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic run_mul(input logic [3:0] x, input logic [3:0] y,
                           input exp_t e, input bit poke);
        int n = 0;
        int nb = 0;
        issue(3'd7, x, y, e, 1'b1);
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (poke && n == 1) begin
                start = 1'b1; op = 3'd0; a = 4'd1; b = 4'd1;
            end
            if (poke && n == 2) start = 1'b0;
        end while (!done && n < 20);
        chk("mul done latency", n, 5);
        chk("mul busy cycles", nb, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", int'(res), 0);
        chk("reset flagC", int'(fc), 0);
        chk("reset flagZ", int'(fz), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 4'd9, 4'd8, '{4'd1, 1'b1, 1'b0}, 1'b1);
        issue(3'd1, 4'd2, 4'd3, '{4'd6, 1'b0, 1'b0}, 1'b1);
        issue(3'd1, 4'd15, 4'd0, '{4'd15, 1'b0, 1'b0}, 1'b1);
        issue(3'd2, 4'd3, 4'd5, '{4'd14, 1'b1, 1'b0}, 1'b1);
        issue(3'd2, 4'd5, 4'd5, '{4'd0, 1'b0, 1'b1}, 1'b1);
        issue(3'd6, 4'd9, 4'd7, '{4'd2, 1'b1, 1'b0}, 1'b1);
        issue(3'd5, 4'd10, 4'd10, '{4'd0, 1'b0, 1'b1}, 1'b1);
        @(posedge clk); #1;

        run_mul(4'd7, 4'd3, '{4'd5, 1'b1, 1'b0}, 1'b1);
        run_mul(4'd3, 4'd4, '{4'd12, 1'b0, 1'b0}, 1'b0);

        issue(3'd7, 4'd15, 4'd15, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort result", int'(res), 0);
        chk("abort flagC", int'(fc), 0);
        chk("abort flagZ", int'(fz), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post-abort busy", int'(busy), 0);

        issue2(3'd0, 4'd9, 4'd8, '{4'd1, 1'b1, 1'b0});
        issue2(3'd7, 4'd5, 4'd5, '{4'd1, 1'b1, 1'b0});
        chk("nomul busy", int'(busy2), 0);
        issue2(3'd3, 4'd12, 4'd10, '{4'd8, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1;

        chk("dut1 queue drained", q1.size(), 0);
        chk("dut2 queue drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
